serial_alu_seq: RTL and testbench
=================================

# serial_alu_seq

Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice and drives it. It accepts a WIDTH-bit operation (AND, OR, ADD, SUB) and presents one operand bit pair per cycle to the slice, LSB first, with the registered carry fed back as the slice's CarryIn. It collects the slice result bits into a WIDTH-bit word and reports completion with carry-out, overflow and zero flags.

## Interface
- WIDTH, 8: operand/result width in bits; legal values 2..32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, active-low, synchronous to clk.
- start  in  1  request; accepted only when busy=0.
- a_in  in  WIDTH  operand A, sampled on the accepting edge.
- b_in  in  WIDTH  operand B, sampled on the accepting edge.
- op_in  in  2  operation code: 00=AND, 01=OR, 10=ADD; 11 is treated as 10.
- sub_in  in  1  subtract flag (SUB = A-B); honoured only when op_in is 10 or 11.
- alu_a  out  1  bit to the slice's a input.
- alu_b  out  1  bit to the slice's b input.
- alu_cin  out  1  carry to the slice's CarryIn input.
- alu_binvert  out  1  to the slice's Binvert input.
- alu_op  out  2  to the slice's Operation input.
- alu_result  in  1  slice Result; combinational from the alu_* outputs.
- alu_cout  in  1  slice CarryOut; combinational from the alu_* outputs.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  assembled result word.
- cout  out  1  final carry-out for ADD/SUB; 0 for logic ops.
- ovf  out  1  signed overflow for ADD/SUB; 0 for logic ops.
- zero  out  1  high when result == 0.

## Operation
The sequencer is a three-state machine: IDLE, RUN, DONE.

- **Reset.** rst_n=0 at a clock edge forces:
  - state IDLE;
  - busy, done, result, cout, ovf, zero, alu_* all 0.
  - This applies in any state, including mid-RUN. The in-flight operation is discarded and no done pulse is produced.
- **IDLE → RUN** on start=1. On that edge the block latches:
  - a_in into A shift register and b_in into B shift register;
  - op_in (11 mapped to 10) into the op register;
  - sub_eff = sub_in & op_in[1];
  - carry register = sub_eff;
  - bit counter = 0.
- **IDLE with start=0:** the block holds. result and the flags keep their last values.
- **RUN, each cycle:**
  - alu_a = A[0], alu_b = B[0], alu_cin = carry register, alu_binvert = sub_eff, alu_op = latched op.
  - On the edge:
    - shift alu_result into the result register from the MSB end, shifting right;
    - shift A and B right;
    - carry register ← alu_cout (logic ops: carry register ← 0);
    - counter increments.
  - On the edge where counter == WIDTH-1 (last bit), also:
    - cout ← alu_cout (ADD/SUB only);
    - ovf ← carry register XOR alu_cout (ADD/SUB only);
    - next state DONE.
- **DONE, one cycle:**
  - done=1 and busy=0.
  - zero = (result == 0), registered on the edge entering DONE.
  - Next state is IDLE.
  - start asserted during DONE is accepted: DONE → RUN directly, and done is still high for this cycle.
- **Outside RUN:** alu_* are 0.
- **start while busy=1** is ignored. Operands are not re-sampled.
- **result, cout, ovf, zero** are updated only at completion and hold until the next completion or reset. The result register is a separate internal shift register copied out on the last edge, so result never shows partial values.
- **Arithmetic** is modulo 2^WIDTH. SUB is A + ~B + 1, realised by Binvert plus an initial carry of 1. For SUB, cout=1 means no borrow.

## Timing
- start is sampled at edge T0.
- busy is high from T0 through edge T0+WIDTH.
- The slice is driven for exactly WIDTH cycles.
- done is high during the cycle after edge T0+WIDTH. Latency from start sample to done is WIDTH+1 cycles.
- result and the flags are valid from the cycle in which done=1.
- Back-to-back throughput is one operation per WIDTH+1 cycles.
- alu_result and alu_cout are sampled in the same cycle the alu_* outputs are driven; no extra pipeline stage.

## Test plan
All scenarios use WIDTH=8 and a behavioural 1-bit ALU slice.
- ADD 0x5A + 0x33 → result 0x8D, cout 0, ovf 1, zero 0; done exactly 9 cycles after start is sampled.
- ADD 0xFF + 0x01 → result 0x00, cout 1, ovf 0, zero 1.
- SUB 0x10 − 0x10 → result 0x00, cout 1, zero 1.
- SUB 0x05 − 0x07 → result 0xFE, cout 0, ovf 0.
- AND 0xF0 & 0x3C → 0x30. OR 0xF0 | 0x0F → 0xFF. For both, cout=0, ovf=0, and alu_binvert stays 0 throughout.
- Control and reset:
  - start pulsed mid-RUN with different operands: the first result is unchanged.
  - rst_n=0 at bit 4: all outputs 0, no done pulse.
  - A new start right after reset completes normally.
  - start held high in DONE: the next operation begins with no idle cycle.

Source files
------------

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial sequencer driving a 1-bit ALU slice
//
// Presents one operand bit pair per cycle (LSB first) to an external 1-bit
// ALU slice. The registered carry is fed back as CarryIn. The slice result
// bits are collected into a WIDTH-bit word. Completion is reported with
// carry-out, signed-overflow and zero flags.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 request, accepted when busy=0 (IDLE or DONE)
//   a_in, b_in            operands, sampled on the accepting edge
//   op_in, sub_in         00=AND 01=OR 10/11=ADD; sub_in selects SUB for ADD
//   alu_a, alu_b, alu_cin, alu_binvert, alu_op
//                         drive to the slice, all 0 outside RUN
//   alu_result, alu_cout  combinational slice outputs, sampled in the same cycle
//   busy, done            in progress / one-cycle completion pulse
//   result, cout, ovf, zero
//                         completed word and flags, held until next completion

module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_in,
    input  logic             sub_in,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic             alu_binvert,
    output logic [1:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             sub_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             run_d;
    logic             arith_d;
    logic             last_d;
    logic [WIDTH-1:0] res_sh_d;

    assign run_d    = (state_q == S_RUN);
    assign arith_d  = op_q[1];
    assign last_d   = (cnt_q == LAST_BIT);
    // Result bits arrive LSB first, so they enter at the MSB and shift right;
    // after WIDTH shifts the first bit has reached bit 0.
    assign res_sh_d = {alu_result, res_sh_q[WIDTH-1:1]};

    // Slice drive is gated so the slice sees a quiet zero input outside RUN.
    assign alu_a       = run_d & a_q[0];
    assign alu_b       = run_d & b_q[0];
    assign alu_cin     = run_d & carry_q;
    assign alu_binvert = run_d & sub_q;
    assign alu_op      = run_d ? op_q : 2'b00;

    assign busy   = run_d;
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                // DONE accepts a new start exactly like IDLE, giving
                // back-to-back operations with no idle cycle.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        op_q    <= op_in[1] ? 2'b10 : op_in;
                        sub_q   <= sub_in & op_in[1];
                        // SUB = A + ~B + 1: the +1 is the initial carry.
                        carry_q <= sub_in & op_in[1];
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_sh_q <= res_sh_d;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= arith_d & alu_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_d) begin
                        result_q <= res_sh_d;
                        zero_q   <= (res_sh_d == '0);
                        cout_q   <= arith_d & alu_cout;
                        // Signed overflow: carry into MSB differs from carry out.
                        ovf_q    <= arith_d & (carry_q ^ alu_cout);
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - randomized self-checking bench for serial_alu_seq

module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       op_in;
    logic             sub_in;
    logic             alu_a;
    logic             alu_b;
    logic             alu_cin;
    logic             alu_binvert;
    logic [1:0]       alu_op;
    logic             alu_result;
    logic             alu_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    int n_vec;
    int n_err;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .op_in       (op_in),
        .sub_in      (sub_in),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_binvert (alu_binvert),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice
    logic bb;
    assign bb = alu_b ^ alu_binvert;
    always_comb begin
        alu_result = 1'b0;
        alu_cout   = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
        case (alu_op)
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            default: alu_result = alu_a ^ bb ^ alu_cin;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, result} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [1:0] op, input logic sub);
        longint ua, ub, m, half, s, sa, sb, t;
        logic [WIDTH-1:0] r;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        m = (longint'(1) << WIDTH) - 1;
        half = (m + 1) / 2;
        if (!op[1]) begin
            r = op[0] ? (a | b) : (a & b);
            c = 1'b0;
            v = 1'b0;
        end else begin
            s = sub ? (ua + ((~ub) & m) + 1) : (ua + ub);
            r = s[WIDTH-1:0];
            c = s[WIDTH];
            sa = a[WIDTH-1] ? ua - (m + 1) : ua;
            sb = b[WIDTH-1] ? ub - (m + 1) : ub;
            t = sub ? sa - sb : sa + sb;
            v = (t < -half) || (t >= half);
        end
        return {c, v, r};
    endfunction

    // Carry into bit k of the arithmetic operation.
    function automatic logic ref_cin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [1:0] op, input logic sub, input int k);
        longint mk, bp, s;
        if (!op[1]) return 1'b0;
        mk = (longint'(1) << k) - 1;
        bp = sub ? longint'(~b) : longint'(b);
        s = (longint'(a) & mk) + (bp & mk) + (sub ? 1 : 0);
        return s[k];
    endfunction

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic sub);
        a_in   = a;
        b_in   = b;
        op_in  = op;
        sub_in = sub;
        start  = 1'b1;
    endtask

    // Follows an operation launched at the current negedge to its done cycle.
    task automatic finish_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [1:0] op, input logic sub, input int inject_at);
        logic [WIDTH+1:0] exp;
        logic [1:0] mop;
        logic seff;
        int cnt;
        bit got;
        bit bad;
        exp  = ref_op(a, b, op, sub);
        mop  = op[1] ? 2'b10 : op;
        seff = sub & op[1];
        cnt  = 0;
        got  = 0;
        bad  = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            cnt++;
            if (inject_at != 0 && cnt == inject_at) begin
                a_in   = ~a;
                b_in   = a ^ b ^ 8'h5a;
                op_in  = op ^ 2'b01;
                sub_in = ~sub;
                start  = 1'b1;
            end else if (inject_at != 0 && cnt == inject_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                got = 1;
            end else if (cnt <= WIDTH) begin
                if (busy !== 1'b1 || alu_a !== a[cnt-1] || alu_b !== b[cnt-1] ||
                    alu_binvert !== seff || alu_op !== mop ||
                    alu_cin !== ref_cin(a, b, op, sub, cnt - 1))
                    bad = 1;
            end
        end
        check({tag, "/latency"}, got ? cnt : 0, WIDTH + 1);
        if (got) begin
            check({tag, "/drive"}, 32'(bad), 0);
            check({tag, "/result"}, 32'(result), 32'(exp[WIDTH-1:0]));
            check({tag, "/cout"}, 32'(cout), 32'(exp[WIDTH+1]));
            check({tag, "/ovf"}, 32'(ovf), 32'(exp[WIDTH]));
            check({tag, "/zero"}, 32'(zero), 32'(exp[WIDTH-1:0] == '0));
            check({tag, "/busy_in_done"}, 32'(busy), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/ctl"}, 32'({busy, done, cout, ovf, zero, alu_a, alu_b, alu_cin, alu_binvert, alu_op}), 0);
        check({tag, "/result"}, 32'(result), 0);
    endtask

    logic [WIDTH-1:0] da [6] = '{8'h5A, 8'hFF, 8'h10, 8'h05, 8'hF0, 8'hF0};
    logic [WIDTH-1:0] db [6] = '{8'h33, 8'h01, 8'h10, 8'h07, 8'h3C, 8'h0F};
    logic [1:0]       dop[6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
    logic             dsb[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [1:0] rop;
        logic rsb;
        logic [WIDTH-1:0] held;
        int dones;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        op_in  = 2'b00;
        sub_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, each started from IDLE; result must hold afterwards.
        for (int i = 0; i < 6; i++) begin
            launch(da[i], db[i], dop[i], dsb[i]);
            finish_op($sformatf("dir%0d", i), da[i], db[i], dop[i], dsb[i], 0);
            held = result;
            @(negedge clk);
            check($sformatf("dir%0d/hold", i), 32'(result), 32'(ref_op(da[i], db[i], dop[i], dsb[i]) & 10'h0FF));
            check($sformatf("dir%0d/idle", i), 32'({busy, done}), 0);
            if (held != result) check("hold_changed", 32'(result), 32'(held));
        end

        // start pulsed mid-RUN with different operands is ignored.
        launch(8'h5A, 8'h33, 2'b10, 1'b0);
        finish_op("midrun", 8'h5A, 8'h33, 2'b10, 1'b0, 3);
        @(negedge clk);
        check("midrun/no_restart", 32'(busy), 0);

        // Reset while bit 4 is being presented.
        launch(8'h12, 8'h34, 2'b10, 1'b0);
        repeat (5) @(negedge clk) start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_midrun");
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_midrun/no_done", 32'(dones), 0);

        // Fresh start after reset, then back-to-back from DONE.
        launch(8'hC3, 8'h3D, 2'b10, 1'b1);
        finish_op("after_rst", 8'hC3, 8'h3D, 2'b10, 1'b1, 0);
        launch(8'h80, 8'h80, 2'b10, 1'b0);
        finish_op("b2b0", 8'h80, 8'h80, 2'b10, 1'b0, 0);
        launch(8'h7F, 8'h80, 2'b11, 1'b1);
        finish_op("b2b1", 8'h7F, 8'h80, 2'b11, 1'b1, 0);

        // Randomized operations, sometimes launched straight from DONE.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rop = 2'($urandom_range(0, 3));
            rsb = 1'($urandom_range(0, 1));
            launch(ra, rb, rop, rsb);
            finish_op($sformatf("rnd%0d", i), ra, rb, rop, rsb, 0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
